// File: rtl/iic_pkg.sv
// Shared types and constants for the IIC audio-codec configuration master.
// Holds the FSM state encoding, bit-cell quarter positions, the default
// target address and the helpers used for divider sizing and byte selection.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Quarter positions inside one SCL bit cell.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // START: Q0-Q1 SDA low with SCL high, Q2 SCL pulled low before the first bit.
  localparam logic [1:0] START_LAST_Q = 2'd2;
  // STOP: Q0 SDA low/SCL low, Q1 SCL high, Q2 SDA released.
  localparam logic [1:0] STOP_LAST_Q  = 2'd2;
  // The ACK is taken on the tick that ends Q1, i.e. at the start of Q2.
  localparam logic [1:0] ACK_SAMPLE_Q = 2'd1;

  // Bus-free time before a START, in quarters (one full SCL period).
  localparam logic [2:0] BUS_FREE_QUARTERS = 3'd4;
  localparam logic [2:0] LAST_BIT          = 3'd7;
  localparam logic [1:0] LAST_BYTE         = 2'd2;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

  // MCLK cycles per SCL quarter, never less than one.
  function automatic int quarter_div(input int clk_hz, input int scl_hz);
    int d;
    d = clk_hz / (4 * scl_hz);
    if (d < 1) begin
      d = 1;
    end
    return d;
  endfunction

  // Byte sent in slot idx: address+write, then shadow high, then shadow low.
  function automatic logic [7:0] byte_select(input logic [1:0]  idx,
                                             input logic [6:0]  addr,
                                             input logic [15:0] shadow);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {addr, 1'b0};
      2'd1:    b = shadow[15:8];
      2'd2:    b = shadow[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/iic_if.sv
// Request/status bundle between a controller and the IIC master.
// The open-drain data pin is not part of this bundle: it stays a plain inout
// on the master so the tristate net resolves directly at the pad.
interface iic_if;
  logic        ENABLE;
  logic [15:0] DATA;
  logic        FINISHED;
  logic        ACK_ERR;
  logic        AUD_SCLK;

  modport master (
    input  ENABLE,
    input  DATA,
    output FINISHED,
    output ACK_ERR,
    output AUD_SCLK
  );

  modport slave (
    output ENABLE,
    output DATA,
    input  FINISHED,
    input  ACK_ERR,
    input  AUD_SCLK
  );
endinterface

// File: rtl/iic_tick_gen.sv
// Free-running divider producing a one-MCLK pulse every DIV cycles; each
// pulse marks one quarter of an SCL period.
module iic_tick_gen #(
  parameter int DIV = 125
) (
  input  logic MCLK,
  input  logic RESET,
  output logic tick
);

  localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_r;
  logic         tick_r;

  // Count MCLK cycles and pulse tick on the terminal count.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      cnt_r  <= {W{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= {W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + W'(1'b1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/iic.sv
// IIC write master: sends {DEV_ADDR,W}, DATA[15:8], DATA[7:0] with an ACK
// cell after each byte, aborting to STOP on the first NACK. Transfers repeat
// while ENABLE is high, separated by at least one SCL period of bus-free time.
module iic
  import iic_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter int         SCL_HZ   = 100_000,
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic  MCLK,
  input  logic  RESET,
  iic_if.master bus,
  inout  wire   AUD_SDAT
);

  localparam int QDIV = quarter_div(CLK_HZ, SCL_HZ);

  state_t      state_r, state_nx_s;
  logic [1:0]  q_r, q_nx_s;
  logic        tick_s;
  logic        launch_s;
  logic        cell_end_s;
  logic [2:0]  idle_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [1:0]  byte_cnt_r;
  logic [15:0] shadow_r;
  logic [7:0]  shift_r;
  logic [1:0]  sda_sync_r;
  logic        ack_err_r;
  logic        scl_s, sda_low_s, finished_s;
  logic        scl_r, sda_low_r, finished_r;

  iic_tick_gen #(.DIV(QDIV)) u_tick_gen (
    .MCLK  (MCLK),
    .RESET (RESET),
    .tick  (tick_s)
  );

  assign launch_s   = (state_r == ST_IDLE) && tick_s && bus.ENABLE &&
                      (idle_cnt_r == BUS_FREE_QUARTERS);
  assign cell_end_s = tick_s && (q_r == Q3);

  // Synchronise the open-drain data line before it is sampled for ACK.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sda_sync_r <= 2'b11;
    end else begin
      sda_sync_r <= {sda_sync_r[0], AUD_SDAT};
    end
  end

  // FSM state and quarter position register.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      q_r     <= Q0;
    end else begin
      state_r <= state_nx_s;
      q_r     <= q_nx_s;
    end
  end

  // Next-state logic: every step except DONE->IDLE waits for a quarter tick.
  always_comb begin
    state_nx_s = state_r;
    q_nx_s     = q_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_nx_s = ST_START;
          q_nx_s     = Q0;
        end else begin
          state_nx_s = ST_IDLE;
          q_nx_s     = Q0;
        end
      end
      ST_START: begin
        if (tick_s && (q_r == START_LAST_Q)) begin
          state_nx_s = ST_BIT;
          q_nx_s     = Q0;
        end else if (tick_s) begin
          q_nx_s = q_r + 2'd1;
        end else begin
          q_nx_s = q_r;
        end
      end
      ST_BIT: begin
        if (cell_end_s && (bit_cnt_r == LAST_BIT)) begin
          state_nx_s = ST_ACK;
          q_nx_s     = Q0;
        end else if (tick_s) begin
          q_nx_s = q_r + 2'd1;
        end else begin
          q_nx_s = q_r;
        end
      end
      ST_ACK: begin
        if (cell_end_s && (ack_err_r || (byte_cnt_r == LAST_BYTE))) begin
          state_nx_s = ST_STOP;
          q_nx_s     = Q0;
        end else if (cell_end_s) begin
          state_nx_s = ST_BIT;
          q_nx_s     = Q0;
        end else if (tick_s) begin
          q_nx_s = q_r + 2'd1;
        end else begin
          q_nx_s = q_r;
        end
      end
      ST_STOP: begin
        if (tick_s && (q_r == STOP_LAST_Q)) begin
          state_nx_s = ST_DONE;
          q_nx_s     = Q0;
        end else if (tick_s) begin
          q_nx_s = q_r + 2'd1;
        end else begin
          q_nx_s = q_r;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        q_nx_s     = Q0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        q_nx_s     = Q0;
      end
    endcase
  end

  // Datapath: bus-free counter, shadow/shift registers, bit/byte counters, ACK error.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      idle_cnt_r <= 3'd0;
      shadow_r   <= 16'h0000;
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      ack_err_r  <= 1'b0;
    end else begin
      if (state_r != ST_IDLE) begin
        idle_cnt_r <= 3'd0;
      end else if (tick_s && (idle_cnt_r != BUS_FREE_QUARTERS)) begin
        idle_cnt_r <= idle_cnt_r + 3'd1;
      end

      if (launch_s) begin
        shadow_r   <= bus.DATA;
        shift_r    <= byte_select(2'd0, DEV_ADDR, bus.DATA);
        bit_cnt_r  <= 3'd0;
        byte_cnt_r <= 2'd0;
        ack_err_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_BIT: begin
            if (cell_end_s) begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? 3'd0 : (bit_cnt_r + 3'd1);
            end
          end
          ST_ACK: begin
            if (tick_s && (q_r == ACK_SAMPLE_Q) && sda_sync_r[1]) begin
              ack_err_r <= 1'b1;
            end
            if (cell_end_s && !ack_err_r && (byte_cnt_r != LAST_BYTE)) begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
              shift_r    <= byte_select(byte_cnt_r + 2'd1, DEV_ADDR, shadow_r);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Bus levels for the current state and quarter.
  always_comb begin
    scl_s      = 1'b1;
    sda_low_s  = 1'b0;
    finished_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
      end
      ST_START: begin
        scl_s     = (q_r != Q2);
        sda_low_s = 1'b1;
      end
      ST_BIT: begin
        scl_s     = (q_r == Q1) || (q_r == Q2);
        sda_low_s = ~shift_r[7];
      end
      ST_ACK: begin
        scl_s     = (q_r == Q1) || (q_r == Q2);
        sda_low_s = 1'b0;
      end
      ST_STOP: begin
        scl_s     = (q_r != Q0);
        sda_low_s = (q_r != STOP_LAST_Q);
      end
      ST_DONE: begin
        scl_s      = 1'b1;
        sda_low_s  = 1'b0;
        finished_s = 1'b1;
      end
      default: begin
        scl_s      = 1'b1;
        sda_low_s  = 1'b0;
        finished_s = 1'b0;
      end
    endcase
  end

  // Register the bus pins and the completion pulse so they are glitch-free.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      scl_r      <= 1'b1;
      sda_low_r  <= 1'b0;
      finished_r <= 1'b0;
    end else begin
      scl_r      <= scl_s;
      sda_low_r  <= sda_low_s;
      finished_r <= finished_s;
    end
  end

  assign AUD_SDAT     = sda_low_r ? 1'b0 : 1'bz;
  assign bus.AUD_SCLK = scl_r;
  assign bus.FINISHED = finished_r;
  assign bus.ACK_ERR  = ack_err_r;

endmodule

// File: tb/tb_iic.sv
// Scoreboard bench for the IIC write master: stimulus pushes expected bus
// events (bytes with ACK bit, STOP, FINISHED with ACK_ERR); a bus monitor
// decodes SCL/SDA, acts as the ACKing slave and compares each event it sees.
module tb_iic;

  localparam int CLK_HZ     = 1_600_000;
  localparam int SCL_HZ     = 100_000;
  localparam int SCL_PERIOD = 16;
  localparam int EV_STOP    = 1024;
  localparam int EV_FIN     = 2048;

  logic MCLK         = 1'b0;
  logic RESET        = 1'b1;
  logic slave_low    = 1'b0;
  logic slave_ack_en = 1'b1;
  wire  AUD_SDAT;

  iic_if bus_if ();

  pullup pu (AUD_SDAT);
  assign AUD_SDAT = slave_low ? 1'b0 : 1'bz;

  iic #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(7'h1A)) dut (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .bus      (bus_if),
    .AUD_SDAT (AUD_SDAT)
  );

  always #5 MCLK = ~MCLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         sb_q[$];
  int         fin_cnt  = 0;
  int         rise_cnt = 0;
  int         scl_low_cyc = 0;
  int         sda_low_cyc = 0;
  int         cyc = 0;
  int         stop_cyc = 0;
  int         bitpos = 0;
  bit         in_xfer = 1'b0;
  bit         stop_seen = 1'b0;
  bit         prev_scl = 1'b1;
  bit         prev_sda = 1'b1;
  bit         prev_fin = 1'b0;
  logic [8:0] shreg = 9'h000;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sb_check(input string name, input int act);
    int exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h but no event was expected", name, act);
    end else begin
      exp = sb_q.pop_front();
      check(name, act, exp);
    end
  endtask

  task automatic wait_fin(input int target, input int budget);
    int n = 0;
    while ((fin_cnt < target) && (n < budget)) begin
      @(negedge MCLK);
      n++;
    end
    check("finished_within_budget", int'(fin_cnt >= target), 1);
  endtask

  task automatic wait_rise(input int target, input int budget);
    int n = 0;
    while ((rise_cnt < target) && (n < budget)) begin
      @(negedge MCLK);
      n++;
    end
    check("scl_rise_within_budget", int'(rise_cnt >= target), 1);
  endtask

  // Bus monitor, ACKing slave and scoreboard comparator.
  initial begin : monitor
    bit scl, sda, fin;
    forever begin
      @(negedge MCLK);
      cyc++;
      scl = bus_if.AUD_SCLK;
      sda = AUD_SDAT;
      fin = bus_if.FINISHED;
      if (RESET) begin
        in_xfer   = 1'b0;
        bitpos    = 0;
        rise_cnt  = 0;
        slave_low = 1'b0;
        stop_seen = 1'b0;
      end else begin
        if (prev_scl && scl && prev_sda && !sda) begin
          check("start_only_when_bus_idle", int'(in_xfer), 0);
          if (stop_seen) begin
            check("bus_free_gap_ge_scl_period", int'((cyc - stop_cyc) >= SCL_PERIOD), 1);
          end
          in_xfer  = 1'b1;
          bitpos   = 0;
          rise_cnt = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
          check("stop_on_frame_boundary", int'(in_xfer && (bitpos == 1)), 1);
          sb_check("stop_event", EV_STOP);
          in_xfer   = 1'b0;
          rise_cnt  = 0;
          stop_seen = 1'b1;
          stop_cyc  = cyc;
        end else if (!prev_scl && scl) begin
          check("scl_rise_inside_transfer", int'(in_xfer), 1);
          shreg = {shreg[7:0], sda};
          bitpos++;
          rise_cnt++;
          if (bitpos == 9) begin
            sb_check("byte_and_ack", int'({shreg[0], shreg[8:1]}));
            bitpos = 0;
          end
        end else if (prev_scl && !scl) begin
          slave_low = in_xfer && (bitpos == 8) && slave_ack_en;
        end
        if (fin) begin
          check("finished_single_cycle", int'(prev_fin), 0);
          sb_check("finished_ack_err", EV_FIN + int'(bus_if.ACK_ERR));
          fin_cnt++;
        end
        if (!scl) scl_low_cyc++;
        if (!sda) sda_low_cyc++;
      end
      prev_scl = scl;
      prev_sda = sda;
      prev_fin = fin;
    end
  end

  // Directed stimulus.
  initial begin : stimulus
    int s0, d0, f0;
    bus_if.ENABLE = 1'b0;
    bus_if.DATA   = 16'h0000;
    RESET         = 1'b1;
    repeat (3) @(negedge MCLK);
    check("reset_scl_high", int'(bus_if.AUD_SCLK), 1);
    check("reset_sda_released", int'(AUD_SDAT), 1);
    check("reset_finished_low", int'(bus_if.FINISHED), 0);
    check("reset_ack_err_low", int'(bus_if.ACK_ERR), 0);
    RESET = 1'b0;

    // ENABLE low: bus must stay idle.
    s0 = scl_low_cyc; d0 = sda_low_cyc; f0 = fin_cnt;
    repeat (1000) @(negedge MCLK);
    check("idle_no_scl_activity", scl_low_cyc - s0, 0);
    check("idle_no_sda_activity", sda_low_cyc - d0, 0);
    check("idle_no_finished", fin_cnt - f0, 0);

    // Two back-to-back transfers, DATA changed after the first FINISHED.
    sb_q.push_back(9'h034); sb_q.push_back(9'h000); sb_q.push_back(9'h017);
    sb_q.push_back(EV_STOP); sb_q.push_back(EV_FIN + 0);
    sb_q.push_back(9'h034); sb_q.push_back(9'h002); sb_q.push_back(9'h017);
    sb_q.push_back(EV_STOP); sb_q.push_back(EV_FIN + 0);
    bus_if.DATA   = 16'h0017;
    bus_if.ENABLE = 1'b1;
    wait_fin(f0 + 1, 3000);
    bus_if.DATA = 16'h0217;
    wait_fin(f0 + 2, 3000);
    bus_if.ENABLE = 1'b0;
    repeat (100) @(negedge MCLK);
    check("two_transfers_all_events_seen", sb_q.size(), 0);
    check("two_transfers_finished_count", fin_cnt - f0, 2);
    check("acked_transfer_ack_err_low", int'(bus_if.ACK_ERR), 0);

    // Slave NACKs the address: STOP right after the ACK cell.
    slave_ack_en = 1'b0;
    sb_q.push_back(9'h134); sb_q.push_back(EV_STOP); sb_q.push_back(EV_FIN + 1);
    bus_if.ENABLE = 1'b1;
    wait_fin(f0 + 3, 3000);
    bus_if.ENABLE = 1'b0;
    repeat (100) @(negedge MCLK);
    check("nack_all_events_seen", sb_q.size(), 0);
    check("nack_ack_err_held", int'(bus_if.ACK_ERR), 1);
    slave_ack_en = 1'b1;

    // Reset during the second bit of the first data byte.
    sb_q.push_back(9'h034);
    bus_if.DATA   = 16'h0F0F;
    bus_if.ENABLE = 1'b1;
    wait_rise(11, 3000);
    check("ack_err_cleared_at_start", int'(bus_if.ACK_ERR), 0);
    #2;
    RESET = 1'b1;
    #1;
    check("midreset_scl_high", int'(bus_if.AUD_SCLK), 1);
    check("midreset_sda_released", int'(AUD_SDAT), 1);
    check("midreset_finished_low", int'(bus_if.FINISHED), 0);
    bus_if.ENABLE = 1'b0;
    repeat (3) @(negedge MCLK);
    RESET = 1'b0;
    s0 = scl_low_cyc; f0 = fin_cnt;
    repeat (300) @(negedge MCLK);
    check("after_reset_no_finished", fin_cnt - f0, 0);
    check("after_reset_no_scl_activity", scl_low_cyc - s0, 0);
    check("after_reset_no_pending_events", sb_q.size(), 0);

    // Recovery transfer; DATA/ENABLE changes mid-transfer must be ignored.
    sb_q.push_back(9'h034); sb_q.push_back(9'h0A5); sb_q.push_back(9'h05A);
    sb_q.push_back(EV_STOP); sb_q.push_back(EV_FIN + 0);
    bus_if.DATA   = 16'hA55A;
    bus_if.ENABLE = 1'b1;
    wait_rise(3, 3000);
    bus_if.DATA   = 16'hFFFF;
    bus_if.ENABLE = 1'b0;
    wait_fin(f0 + 1, 3000);
    repeat (100) @(negedge MCLK);
    check("recovery_all_events_seen", sb_q.size(), 0);
    check("recovery_single_finished", fin_cnt - f0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
